// File: rtl/unidade_busca_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unidade_busca_pkg
// Description : Shared defaults and state encoding for the instruction-fetch
//               sequencer (unidade_busca) and its prefetch FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package unidade_busca_pkg;

    // Default widths and reset address of the 8-bit processor.
    localparam int            LARGURA_END_PADRAO   = 8;
    localparam int            LARGURA_INSTR_PADRAO = 8;
    localparam logic [7:0]    END_INICIAL_PADRAO   = 8'h00;

    // Fetch state machine encoding.
    typedef logic [0:0] estado_t;
    localparam logic [0:0] BUSCANDO = 1'b0;  // issuing fetches
    localparam logic [0:0] PARADO   = 1'b1;  // halted, buffer drains

endpackage : unidade_busca_pkg
`default_nettype wire

// File: rtl/unidade_busca_fifo_busca.sv
`default_nettype none
// ============================================================================
// Module      : fifo_busca
// Description : PROFUNDIDADE-entry prefetch FIFO of {instr, addr} words.
//               Head entry is always presented on dado_saida.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n      - clock, async active-low reset
//               push, pop      - write / read strobes (pop when empty ignored)
//               flush          - empties the FIFO, wins over push and pop
//               dado_entrada   - word to write
//               dado_saida     - head word (VALOR_RESET after reset)
//               contagem       - number of stored entries
// ============================================================================
module fifo_busca
    import unidade_busca_pkg::*;
#(
    parameter int                 LARGURA      = 16,
    parameter int                 PROFUNDIDADE = 2,
    parameter int                 LARGURA_CONT = $clog2(PROFUNDIDADE) + 1,
    parameter logic [LARGURA-1:0] VALOR_RESET  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [LARGURA-1:0]      dado_entrada,
    output logic [LARGURA-1:0]      dado_saida,
    output logic [LARGURA_CONT-1:0] contagem
);

    localparam int LARGURA_PTR = $clog2(PROFUNDIDADE);

    logic [LARGURA-1:0]      mem_q [PROFUNDIDADE];
    logic [LARGURA-1:0]      mem_d [PROFUNDIDADE];
    logic [LARGURA_PTR-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LARGURA_PTR-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LARGURA_CONT-1:0] contagem_q, contagem_d;

    logic push_ok;
    logic pop_ok;
    logic cheio;

    assign cheio   = (contagem_q == LARGURA_CONT'(PROFUNDIDADE));
    // A flush discards whatever would have been written on the same edge.
    assign push_ok = push & ~flush;
    assign pop_ok  = pop & (contagem_q != '0);

    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        contagem_d = contagem_q;
        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            contagem_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = dado_entrada;
                // Power-of-two depth: pointers wrap by natural overflow.
                wr_ptr_d        = wr_ptr_q + LARGURA_PTR'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + LARGURA_PTR'(1);
            end
            contagem_d = contagem_q + LARGURA_CONT'(push_ok) - LARGURA_CONT'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PROFUNDIDADE; i++) begin
                mem_q[i] <= VALOR_RESET;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            contagem_q <= '0;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            contagem_q <= contagem_d;
        end
    end

    assign dado_saida = mem_q[rd_ptr_q];
    assign contagem   = contagem_q;

    // The issuing logic reserves a slot before every fetch, so a write into
    // a full FIFO means that reservation arithmetic is broken.
    a_sem_estouro : assert property (@(posedge clk) disable iff (!rst_n)
                                     !(push_ok && cheio))
        else $error("fifo_busca: push into full FIFO");

endmodule : fifo_busca
`default_nettype wire

// File: rtl/unidade_busca.sv
`default_nettype none
// ============================================================================
// Module      : unidade_busca
// Description : Instruction-fetch sequencer. Owns the PC, drives a memory
//               with 1-cycle synchronous read, buffers returned instructions
//               and hands them to decode over Valido/Pronto. Supports branch
//               redirect with flush (Desvio) and halt (Parar).
// Revision    : 1.0 - initial release
// Ports       : Clock, Reset      - clock, async active-low reset
//               Endereco          - fetch address (PC register)
//               Instrucao         - memory data for previous-edge address
//               Instrucao_saida   - head instruction to decode
//               Valido / Pronto   - decode handshake
//               Desvio            - one-cycle redirect request
//               Endereco_desvio   - redirect target
//               Parar             - level halt request
//               PC_atual          - address of Instrucao_saida
// ============================================================================
module unidade_busca
    import unidade_busca_pkg::*;
#(
    parameter int                     LARGURA_END   = LARGURA_END_PADRAO,
    parameter int                     LARGURA_INSTR = LARGURA_INSTR_PADRAO,
    parameter int                     PROFUNDIDADE  = 2,
    parameter logic [LARGURA_END-1:0] END_INICIAL   = LARGURA_END'(END_INICIAL_PADRAO)
) (
    input  logic                     Clock,
    input  logic                     Reset,
    output logic [LARGURA_END-1:0]   Endereco,
    input  logic [LARGURA_INSTR-1:0] Instrucao,
    output logic [LARGURA_INSTR-1:0] Instrucao_saida,
    output logic                     Valido,
    input  logic                     Pronto,
    input  logic                     Desvio,
    input  logic [LARGURA_END-1:0]   Endereco_desvio,
    input  logic                     Parar,
    output logic [LARGURA_END-1:0]   PC_atual
);

    localparam int LARGURA_ENTRADA = LARGURA_INSTR + LARGURA_END;
    localparam int LARGURA_CONT    = $clog2(PROFUNDIDADE) + 1;
    localparam int LARGURA_OCUP    = LARGURA_CONT + 1;

    estado_t                  estado_q, estado_d;
    logic [LARGURA_END-1:0]   pc_q, pc_d;
    logic                     em_voo_q, em_voo_d;
    logic [LARGURA_END-1:0]   end_voo_q, end_voo_d;

    logic [LARGURA_CONT-1:0]    contagem;
    logic [LARGURA_ENTRADA-1:0] cabeca;
    logic [LARGURA_OCUP-1:0]    ocupacao;
    logic                       pop;
    logic                       push;
    logic                       emite;

    assign Valido = (contagem != '0);
    assign pop    = Valido & Pronto;

    // Slots that will be occupied after this edge if nothing new is issued:
    // stored entries plus the fetch already in flight, minus the one leaving.
    assign ocupacao = LARGURA_OCUP'(contagem) + LARGURA_OCUP'(em_voo_q)
                    - LARGURA_OCUP'(pop);
    assign emite    = (estado_q == BUSCANDO) & ~Desvio
                    & (ocupacao < LARGURA_OCUP'(PROFUNDIDADE));

    // In-flight data belongs to the old path when a redirect arrives.
    assign push = em_voo_q & ~Desvio;

    always_comb begin
        estado_d  = estado_q;
        pc_d      = pc_q;
        end_voo_d = end_voo_q;
        em_voo_d  = emite;

        case (estado_q)
            BUSCANDO: if (Parar)  estado_d = PARADO;
            PARADO:   if (!Parar) estado_d = BUSCANDO;
            default:  estado_d = BUSCANDO;
        endcase

        if (Desvio) begin
            pc_d = Endereco_desvio;
        end else if (emite) begin
            pc_d      = pc_q + LARGURA_END'(1);
            end_voo_d = pc_q;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            estado_q  <= BUSCANDO;
            pc_q      <= END_INICIAL;
            em_voo_q  <= 1'b0;
            end_voo_q <= END_INICIAL;
        end else begin
            estado_q  <= estado_d;
            pc_q      <= pc_d;
            em_voo_q  <= em_voo_d;
            end_voo_q <= end_voo_d;
        end
    end

    fifo_busca #(
        .LARGURA      (LARGURA_ENTRADA),
        .PROFUNDIDADE (PROFUNDIDADE),
        .LARGURA_CONT (LARGURA_CONT),
        .VALOR_RESET  ({{LARGURA_INSTR{1'b0}}, END_INICIAL})
    ) u_fifo_busca (
        .clk          (Clock),
        .rst_n        (Reset),
        .push         (push),
        .pop          (pop),
        .flush        (Desvio),
        .dado_entrada ({Instrucao, end_voo_q}),
        .dado_saida   (cabeca),
        .contagem     (contagem)
    );

    assign Endereco        = pc_q;
    assign Instrucao_saida = cabeca[LARGURA_ENTRADA-1:LARGURA_END];
    assign PC_atual        = cabeca[LARGURA_END-1:0];

endmodule : unidade_busca
`default_nettype wire

// File: doc/unidade_busca.md
Name: unidade_busca

Overview:
Instruction-fetch sequencer for the 8-bit processor. Owns the program counter and drives the address port of MenoriaInstrucao, which has a 1-cycle synchronous read: the address is sampled on a rising edge and Instrucao is valid after that edge. Captured instructions go into a small prefetch buffer and are handed to decode over a valid/ready handshake. Supports branch redirect with flush, and halt.

Parameters:
LARGURA_END, 8, PC / memory address width
LARGURA_INSTR, 8, instruction width
PROFUNDIDADE, 2, prefetch buffer entries (power of 2, >=2)
END_INICIAL, 8'h00, PC value after reset

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Endereco  out  LARGURA_END  address to MenoriaInstrucao; equals PC register
Instrucao  in  LARGURA_INSTR  read data from MenoriaInstrucao, for the address presented on the previous edge
Instrucao_saida  out  LARGURA_INSTR  head of prefetch buffer
Valido  out  1  buffer non-empty; Instrucao_saida meaningful
Pronto  in  1  decode accepts; transfer when Valido & Pronto at rising edge
Desvio  in  1  redirect request, one cycle
Endereco_desvio  in  LARGURA_END  redirect target, sampled with Desvio
Parar  in  1  level; while high, no new fetches are issued
PC_atual  out  LARGURA_END  address of Instrucao_saida, for PC-relative branches in decode

Behaviour:
- Reset low, async: PC=END_INICIAL, buffer empty, em_voo=0, Valido=0, Instrucao_saida=0, PC_atual=END_INICIAL, state BUSCANDO. Any in-progress state is discarded.
- pop = Valido & Pronto.
- emite = (state==BUSCANDO) & !Desvio & (count + em_voo - pop < PROFUNDIDADE).
- On an edge with emite: PC<=PC+1 (mod 2^LARGURA_END, so FF wraps to 00), em_voo<=1, and the address of the issued fetch is recorded. Otherwise em_voo<=0.
- When em_voo=1 at an edge: push {Instrucao, recorded address} into the buffer.
- Latency: first Valido rises after the 2nd rising edge following Reset release. With Pronto held at 1, one instruction per cycle with no bubbles.
- Buffer boundaries:
  - Simultaneous push and pop: count is unchanged.
  - The emite rule guarantees the buffer never overflows. Push-when-full is a design error and must be asserted against.
  - Pop when empty is ignored.
- Desvio (highest priority): on that edge, PC<=Endereco_desvio, buffer flushed, em_voo<=0 (in-flight data dropped). A pop in the same edge still counts as consumed. The target is issued on the next edge, and its data appears 2 edges after Desvio.
- States:
  - BUSCANDO: Parar=1 moves to PARADO.
  - PARADO: no issues, the in-flight fetch still completes, buffer drains normally. Parar=0 returns to BUSCANDO and resumes at the current PC.
  - Desvio in PARADO updates PC and flushes; fetching waits for Parar=0.
- Endereco is always the PC register; the memory may read every cycle, and data is captured only when em_voo=1.

Decomposition:
- Shared package: LARGURA_END, LARGURA_INSTR, END_INICIAL defaults; state encoding BUSCANDO/PARADO.
- One sub-module, fifo_busca: PROFUNDIDADE-entry FIFO of {instr, addr} with push, pop, flush, count, and async active-low reset.

Test Plan (memory preloaded mem[i]=~i):
- Reset release, Pronto=1, Parar=0 -> Endereco 00,01,02...; Valido rises after 2nd edge; outputs FF,FE,FD... one per cycle, with PC_atual 00,01,02.
- Pronto=0 for 5 cycles mid-stream -> count saturates at 2; Endereco holds at last_accepted+3; on Pronto=1 the stream continues with no loss or duplication.
- Desvio=1, Endereco_desvio=40 while em_voo=1 -> no stale instruction appears; next Valido output is BF with PC_atual=40, 2 edges after Desvio.
- Desvio to FE, Pronto=1 -> Endereco FE,FF,00,01; outputs 01,00,FF,FE.
- Parar=1 for 6 cycles -> issues stop, buffer drains, Valido=0; Parar=0 resumes at the next sequential address with no skip.
- Reset pulsed low between edges mid-stream -> immediately Valido=0, Endereco=00; restart matches the first scenario.
